// File: rtl/vfifo_pkg.sv
// Shared widths and geometry helpers for the vfifo queue controller slice.
package vfifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 9;
    localparam int QSEL_WIDTH_DEF = 2;

    function automatic int nq_of(input int qsel_width);
        return 1 << qsel_width;
    endfunction

    function automatic int depth_of(input int addr_width, input int qsel_width);
        return 1 << (addr_width - qsel_width);
    endfunction

    function automatic int ptr_width_of(input int addr_width, input int qsel_width);
        return addr_width - qsel_width;
    endfunction

    // One extra bit so a completely full queue (cnt == D) is representable.
    function automatic int cnt_width_of(input int addr_width, input int qsel_width);
        return addr_width - qsel_width + 1;
    endfunction

endpackage

// File: rtl/vfifo_sc_queue_state.sv
// Per-queue bookkeeping: read/write pointers, occupancy count and registered full/empty flags.
module vfifo_sc_queue_state #(
    parameter int PTR_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    output logic [PTR_WIDTH-1:0] wptr,
    output logic [PTR_WIDTH-1:0] rptr,
    output logic                 full,
    output logic                 empty
);

    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int DEPTH     = 1 << PTR_WIDTH;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            cnt_next = cnt - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_WIDTH'(1);
            end
            cnt   <= cnt_next;
            full  <= (cnt_next == CNT_WIDTH'(DEPTH));
            empty <= (cnt_next == '0);
        end
    end

endmodule

// File: rtl/vfifo_sc_queue_ctrl.sv
// Multi-queue FIFO controller: carves one dual-port RAM (1-cycle read) into 2**QSEL_WIDTH circular queues.
module vfifo_sc_queue_ctrl
    import vfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int QSEL_WIDTH = QSEL_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_req,
    input  logic [QSEL_WIDTH-1:0]           wr_sel,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_ack,
    input  logic                            rd_req,
    input  logic [QSEL_WIDTH-1:0]           rd_sel,
    output logic                            rd_ack,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid,
    input  logic [nq_of(QSEL_WIDTH)-1:0]    flush,
    output logic [nq_of(QSEL_WIDTH)-1:0]    full,
    output logic [nq_of(QSEL_WIDTH)-1:0]    empty,
    output logic [DATA_WIDTH-1:0]           ram_d_a,
    output logic [ADDR_WIDTH-1:0]           ram_adr_a,
    output logic                            ram_we_a,
    output logic [ADDR_WIDTH-1:0]           ram_adr_b,
    input  logic [DATA_WIDTH-1:0]           ram_q_b
);

    localparam int NQ    = nq_of(QSEL_WIDTH);
    localparam int PTR_W = ptr_width_of(ADDR_WIDTH, QSEL_WIDTH);

    logic [PTR_W-1:0] wptr [NQ];
    logic [PTR_W-1:0] rptr [NQ];
    logic [NQ-1:0]    push;
    logic [NQ-1:0]    pop;

    // Acceptance uses registered flags only: no pass-through on full, no bypass on empty.
    assign wr_ack = wr_req & ~full[wr_sel]  & ~flush[wr_sel] & ~rst;
    assign rd_ack = rd_req & ~empty[rd_sel] & ~flush[rd_sel] & ~rst;

    always_comb begin
        push         = '0;
        pop          = '0;
        push[wr_sel] = wr_ack;
        pop[rd_sel]  = rd_ack;
    end

    assign ram_d_a   = wr_data;
    assign ram_we_a  = wr_ack;
    assign ram_adr_a = {wr_sel, wptr[wr_sel]};
    assign ram_adr_b = {rd_sel, rptr[rd_sel]};
    assign rd_data   = ram_q_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ack;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        vfifo_sc_queue_state #(
            .PTR_WIDTH(PTR_W)
        ) u_state (
            .clk  (clk),
            .rst  (rst),
            .push (push[q]),
            .pop  (pop[q]),
            .flush(flush[q]),
            .wptr (wptr[q]),
            .rptr (rptr[q]),
            .full (full[q]),
            .empty(empty[q])
        );
    end

endmodule

// File: tb/tb_vfifo_sc_queue_ctrl.sv
// Directed and randomized bench for vfifo_sc_queue_ctrl against a queue-based reference model.
module tb_vfifo_sc_queue_ctrl;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int QW = 2;
    localparam int NQ = 4;
    localparam int D  = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [QW-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [QW-1:0] rd_sel;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [NQ-1:0] flush;
    logic [NQ-1:0] full;
    logic [NQ-1:0] empty;
    logic [DW-1:0] ram_d_a;
    logic [AW-1:0] ram_adr_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_adr_b;
    logic [DW-1:0] ram_q_b;

    int checks   = 0;
    int failures = 0;

    vfifo_sc_queue_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .QSEL_WIDTH(QW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .ram_d_a  (ram_d_a),
        .ram_adr_a(ram_adr_a),
        .ram_we_a (ram_we_a),
        .ram_adr_b(ram_adr_b),
        .ram_q_b  (ram_q_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read port.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    // Reference model: contents of each queue plus push/pop totals since last clear.
    logic [DW-1:0] qm [NQ][$];
    int            wcnt [NQ];
    int            rcnt [NQ];
    logic          pend_valid = 1'b0;
    logic [DW-1:0] pend_data  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int q);
        qm[q].delete();
        wcnt[q] = 0;
        rcnt[q] = 0;
    endtask

    // One clock: drive after negedge, check combinational outputs, step model at posedge,
    // then check registered outputs at the following negedge.
    task automatic cycle(input logic wreq, input logic [QW-1:0] wsel, input logic [DW-1:0] wdata,
                         input logic rreq, input logic [QW-1:0] rsel,
                         input logic [NQ-1:0] fl, input logic r);
        logic          ew;
        logic          er;
        logic [NQ-1:0] exp_full;
        logic [NQ-1:0] exp_empty;
        wr_req  = wreq;
        wr_sel  = wsel;
        wr_data = wdata;
        rd_req  = rreq;
        rd_sel  = rsel;
        flush   = fl;
        rst     = r;
        #1;
        ew = wreq && (qm[wsel].size() < D) && !fl[wsel] && !r;
        er = rreq && (qm[rsel].size() > 0) && !fl[rsel] && !r;
        chk("wr_ack",    32'(wr_ack),    32'(ew));
        chk("rd_ack",    32'(rd_ack),    32'(er));
        chk("ram_we_a",  32'(ram_we_a),  32'(ew));
        chk("ram_adr_a", 32'(ram_adr_a), 32'(int'(wsel) * D + (wcnt[wsel] % D)));
        chk("ram_adr_b", 32'(ram_adr_b), 32'(int'(rsel) * D + (rcnt[rsel] % D)));
        if (ew) chk("ram_d_a", 32'(ram_d_a), 32'(wdata));
        @(posedge clk);
        if (r) begin
            for (int q = 0; q < NQ; q++) model_clear(q);
        end else begin
            for (int q = 0; q < NQ; q++) if (fl[q]) model_clear(q);
        end
        if (ew) begin
            qm[wsel].push_back(wdata);
            wcnt[wsel]++;
        end
        pend_valid = er;
        if (er) begin
            pend_data = qm[rsel].pop_front();
            rcnt[rsel]++;
        end
        @(negedge clk);
        chk("rd_valid", 32'(rd_valid), 32'(pend_valid));
        if (pend_valid) chk("rd_data", 32'(rd_data), 32'(pend_data));
        for (int q = 0; q < NQ; q++) begin
            exp_full[q]  = (qm[q].size() == D);
            exp_empty[q] = (qm[q].size() == 0);
        end
        chk("full",  32'(full),  32'(exp_full));
        chk("empty", 32'(empty), 32'(exp_empty));
    endtask

    task automatic push_only(input logic [QW-1:0] q, input logic [DW-1:0] d);
        cycle(1'b1, q, d, 1'b0, 2'd0, 4'b0000, 1'b0);
    endtask

    task automatic pop_only(input logic [QW-1:0] q);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, q, 4'b0000, 1'b0);
    endtask

    initial begin
        for (int q = 0; q < NQ; q++) model_clear(q);
        rst = 1'b1; wr_req = 1'b0; wr_sel = '0; wr_data = '0;
        rd_req = 1'b0; rd_sel = '0; flush = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with requests asserted: nothing may be acked or written.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 8'h5A, 1'b1, 2'(i), 4'b0000, 1'b1);

        // Queue 2 basic FIFO order, back-to-back pops.
        push_only(2'd2, 8'h11);
        push_only(2'd2, 8'h22);
        push_only(2'd2, 8'h33);
        for (int i = 0; i < 3; i++) pop_only(2'd2);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Fill queue 1, overfill attempt, then same-cycle push+pop on full queue.
        for (int i = 0; i < D; i++) push_only(2'd1, 8'(i + 3));
        push_only(2'd1, 8'hEE);
        cycle(1'b1, 2'd1, 8'hEF, 1'b1, 2'd1, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Queue 0 wrap: hold occupancy at 5 through 200 push/pop pairs.
        for (int i = 0; i < 5; i++) push_only(2'd0, 8'(8'hC0 + i));
        for (int i = 0; i < 200; i++) cycle(1'b1, 2'd0, 8'($urandom), 1'b1, 2'd0, 4'b0000, 1'b0);

        // Queue 3 empty: simultaneous push and pop, pop refused, then pop it.
        cycle(1'b1, 2'd3, 8'hAA, 1'b1, 2'd3, 4'b0000, 1'b0);
        pop_only(2'd3);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Flush queue 2 holding 10 words while pushing to it and popping queue 0.
        for (int i = 0; i < 10; i++) push_only(2'd2, 8'(8'h40 + i));
        pop_only(2'd0);
        cycle(1'b1, 2'd2, 8'h99, 1'b1, 2'd0, 4'b0100, 1'b0);
        pop_only(2'd0);
        cycle(1'b1, 2'd1, 8'h77, 1'b1, 2'd0, 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Randomized traffic with occasional flushes and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic [NQ-1:0] fl;
            fl = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            cycle(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)),
                  fl, ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
